// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and
// the default stop-bit level.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STOP  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam bit STOP_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/frame_shift_reg.sv
// Right-shifting payload register. New bits enter at the MSB, so the first
// bit received ends up in pout[0] once WIDTH bits have been shifted in.
module frame_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] pout
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  generate
    if (WIDTH == 1) begin : g_single
      always_comb begin
        sr_d = sr_q;
        if (en) sr_d = serial_in;
      end
    end else begin : g_multi
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      always_comb begin
        sr_d = sr_q;
        if (en) sr_d = {serial_in, sr_q[WIDTH-1:1]};
      end
    end
  endgenerate

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign pout = sr_q;

endmodule

// File: rtl/serial_frame_controller.sv
// Serial frame receiver: detects a start rise, shifts DATA_BITS payload bits,
// checks the stop bit and holds the frame until the consumer accepts it.
module serial_frame_controller
  import serial_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit STOP_LEVEL = STOP_LEVEL_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 wake_transmitter
);

  localparam int               CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_in_q, prev_in_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_err_q, overrun_err_d;
  logic             wake_q, wake_d;
  logic             rise;
  logic             shift_en;

  assign rise = serial_in & ~prev_in_q;

  // prev_in resets high so a line already idling high at reset release is not a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      prev_in_q     <= 1'b1;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      wake_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_in_q     <= prev_in_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      wake_q        <= wake_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_in_d = serial_in;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d = (serial_in == STOP_LEVEL) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (data_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A rise seen in HOLD is only flagged; it never starts a frame, even on the accepting edge.
  always_comb begin
    shift_en      = (state_q == ST_SHIFT);
    busy          = (state_q != ST_IDLE);
    data_valid    = (state_q == ST_HOLD);
    frame_err_d   = (state_q == ST_STOP) && (serial_in != STOP_LEVEL);
    overrun_err_d = (state_q == ST_HOLD) && rise;
    wake_d        = (state_q == ST_HOLD) && data_ready;
  end

  assign frame_err        = frame_err_q;
  assign overrun_err      = overrun_err_q;
  assign wake_transmitter = wake_q;

  frame_shift_reg #(
    .WIDTH (DATA_BITS)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .en        (shift_en),
    .serial_in (serial_in),
    .pout      (data_out)
  );

endmodule

// File: tb/tb_serial_frame_controller.sv
// Self-checking bench for serial_frame_controller: directed scenarios plus
// random frames, compared against expectations derived from the frame rules.
module tb_serial_frame_controller;

  localparam int DB   = 8;
  localparam bit STOP = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          serial_in = 1'b0;
  logic          data_ready = 1'b0;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          frame_err;
  logic          overrun_err;
  logic          wake_transmitter;

  int n_checks = 0;
  int n_fail   = 0;

  serial_frame_controller #(
    .DATA_BITS  (DB),
    .STOP_LEVEL (STOP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .serial_in        (serial_in),
    .data_ready       (data_ready),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .busy             (busy),
    .frame_err        (frame_err),
    .overrun_err      (overrun_err),
    .wake_transmitter (wake_transmitter)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then look at outputs just after the next rising edge.
  task automatic step(input logic si, input logic rdy);
    @(negedge clk);
    serial_in  = si;
    data_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_no_pulses(input string tag);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"}, overrun_err, 0);
    check({tag, "_wake"}, wake_transmitter, 0);
  endtask

  // Send one frame: optional low cycle, start rise, DB payload bits LSB first, stop bit.
  task automatic run_frame(input logic [DB-1:0] payload, input logic stop_bit, input bit lead_low);
    bit good;
    good = (stop_bit == STOP);
    if (lead_low) begin
      step(1'b0, 1'b0);
      check("lead_busy", busy, 0);
    end
    step(1'b1, 1'b0);
    check("rise_busy", busy, 1);
    check("rise_valid", data_valid, 0);
    check_no_pulses("rise");
    for (int i = 0; i < DB; i++) begin
      step(payload[i], 1'b0);
      check("shift_valid", data_valid, 0);
      check("shift_busy", busy, 1);
    end
    step(stop_bit, 1'b0);
    check("stop_valid", data_valid, good ? 1 : 0);
    check("stop_frame_err", frame_err, good ? 0 : 1);
    check("stop_busy", busy, good ? 1 : 0);
    if (good) check("stop_data", data_out, payload);
  endtask

  // Keep the frame waiting wait_cycles cycles, then accept it with the line low.
  task automatic consume(input logic [DB-1:0] exp, input int unsigned wait_cycles);
    for (int i = 0; i < int'(wait_cycles); i++) begin
      step(1'b0, 1'b0);
      check("hold_valid", data_valid, 1);
      check("hold_data", data_out, exp);
      check("hold_wake", wake_transmitter, 0);
    end
    step(1'b0, 1'b1);
    check("accept_wake", wake_transmitter, 1);
    check("accept_valid", data_valid, 0);
    check("accept_busy", busy, 0);
  endtask

  initial begin
    logic [DB-1:0] p1;
    logic [DB-1:0] p2;
    logic          sb;
    bit            lead;

    // Reset values while rst is asserted.
    #2 rst = 1'b1;
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check_no_pulses("rst");

    // Release with the line high: no false start.
    @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("release_busy", busy, 0);
    end

    // Reference frame 0x4D, then a 5-cycle wait before acceptance.
    run_frame(8'h4D, STOP, 1'b1);
    consume(8'h4D, 5);

    // Same frame with a bad stop bit.
    run_frame(8'h4D, ~STOP, 1'b1);
    step(1'b1, 1'b0);
    check("ferr_clear", frame_err, 0);
    check("ferr_idle_busy", busy, 0);
    check("ferr_idle_valid", data_valid, 0);

    // Overrun in HOLD: first without, then with data_ready in the same cycle.
    p1 = DB'($urandom);
    run_frame(p1, STOP, 1'b1);
    step(1'b1, 1'b0);
    check("ovr1_pulse", overrun_err, 1);
    check("ovr1_valid", data_valid, 1);
    check("ovr1_data", data_out, p1);
    step(1'b0, 1'b0);
    check("ovr1_clear", overrun_err, 0);
    step(1'b1, 1'b1);
    check("ovr2_pulse", overrun_err, 1);
    check("ovr2_wake", wake_transmitter, 1);
    check("ovr2_busy", busy, 0);
    step(1'b1, 1'b0);
    check("ovr2_after_busy", busy, 0);
    check_no_pulses("ovr2_after");

    // Reset mid-frame at the fourth data edge, then a clean 0xA5 frame.
    p1 = DB'($urandom);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(p1[i], 1'b0);
    @(negedge clk);
    serial_in = p1[3];
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_data", data_out, 0);
    check_no_pulses("midrst");
    @(negedge clk);
    serial_in = 1'b1;
    rst = 1'b0;
    step(1'b1, 1'b0);
    check("midrst_idle", busy, 0);
    run_frame(8'hA5, STOP, 1'b1);
    consume(8'hA5, 0);

    // Back-to-back: second rise in the first IDLE cycle after the handshake.
    p1 = DB'($urandom);
    p2 = DB'($urandom);
    run_frame(p1, STOP, 1'b1);
    consume(p1, $urandom_range(0, 3));
    run_frame(p2, STOP, 1'b0);
    consume(p2, $urandom_range(0, 3));

    // Random frames; a quarter carry a bad stop bit.
    for (int f = 0; f < 8; f++) begin
      p1   = DB'($urandom);
      sb   = ($urandom_range(0, 3) == 0) ? ~STOP : STOP;
      lead = (serial_in == 1'b1) ? 1'b1 : 1'($urandom_range(0, 1));
      run_frame(p1, sb, lead);
      if (sb == STOP) consume(p1, $urandom_range(0, 4));
    end
    step(1'b0, 1'b0);
    check("final_busy", busy, 0);
    check_no_pulses("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
